// File: rtl/vec_div_sequencer_if.sv
// Bundle between the vector divide sequencer, its requester and the shared
// combinational divider. The slave modport is the sequencer's view.
interface vec_div_sequencer_if #(
  parameter int N     = 8,
  parameter int LANES = 4
);
  logic                 start;
  logic [LANES*N-1:0]   a_vec;
  logic [LANES*N-1:0]   b_vec;
  logic [LANES-1:0]     mask;
  logic [N-1:0]         div_a;
  logic [N-1:0]         div_b;
  logic [N-1:0]         div_out;
  logic                 div_ovf;
  logic                 busy;
  logic                 done;
  logic [LANES*N-1:0]   result;
  logic [LANES-1:0]     ovf_flags;
  logic [LANES-1:0]     dz_flags;

  modport slave (
    input  start, a_vec, b_vec, mask, div_out, div_ovf,
    output div_a, div_b, busy, done, result, ovf_flags, dz_flags
  );

  modport master (
    output start, a_vec, b_vec, mask, div_out, div_ovf,
    input  div_a, div_b, busy, done, result, ovf_flags, dz_flags
  );
endinterface

// File: rtl/vec_div_sequencer.sv
// Issues one lane per cycle of a latched vector divide to a shared signed
// divider, handling divide-by-zero locally and pulsing done when complete.
module vec_div_sequencer #(
  parameter int N     = 8,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  vec_div_sequencer_if.slave bus
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [IW-1:0]      idx;
  logic [LANES*N-1:0] a_lat, b_lat, result;
  logic [LANES-1:0]   mask_lat, ovf_flags, dz_flags;
  logic               busy, done;
  logic [N-1:0]       a_lane, b_lane;
  logic               lane_en, b_zero, accept, last, div_go;

  assign a_lane  = a_lat[idx*N +: N];
  assign b_lane  = b_lat[idx*N +: N];
  assign lane_en = mask_lat[idx];
  assign b_zero  = (b_lane == '0);
  assign last    = (idx == LAST);
  assign accept  = (state != RUN) && bus.start;
  assign div_go  = (state == RUN) && lane_en && !b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = accept ? RUN : IDLE;
      RUN:     next_state = last ? DONE : RUN;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Idle divider inputs are 0/1 so the shared divider never sees a zero divisor.
  always_comb begin
    bus.div_a = '0;
    bus.div_b = N'(1);
    if (div_go) begin
      bus.div_a = a_lane;
      bus.div_b = b_lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      mask_lat  <= '0;
      result    <= '0;
      ovf_flags <= '0;
      dz_flags  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == DONE);
      if (accept) begin
        a_lat     <= bus.a_vec;
        b_lat     <= bus.b_vec;
        mask_lat  <= bus.mask;
        result    <= '0;
        ovf_flags <= '0;
        dz_flags  <= '0;
        idx       <= '0;
      end else if (state == RUN) begin
        if (lane_en) begin
          if (b_zero) begin
            result[idx*N +: N] <= '1;
            dz_flags[idx]      <= 1'b1;
            ovf_flags[idx]     <= 1'b0;
          end else begin
            result[idx*N +: N] <= bus.div_out;
            ovf_flags[idx]     <= bus.div_ovf;
          end
        end
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.ovf_flags = ovf_flags;
  assign bus.dz_flags  = dz_flags;
endmodule

// File: tb/tb_vec_div_sequencer.sv
// Directed bench for vec_div_sequencer; the bench also plays the shared
// signed divider so every lane sees a real quotient.
module tb_vec_div_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   q_model;
  int   busy_cnt;
  int   done_at;
  logic [7:0] lane_da [4];
  logic [7:0] lane_db [4];

  localparam logic [31:0] A_BASIC = 32'h7F09F914;
  localparam logic [31:0] B_BASIC = 32'h01FC0203;
  localparam logic [31:0] R_BASIC = 32'h7FFEFD06;
  localparam logic [31:0] A_DZ    = 32'h05050505;
  localparam logic [31:0] B_DZ    = 32'hFF050001;
  localparam logic [31:0] R_DZ    = 32'hFB01FF05;

  vec_div_sequencer_if #(.N(8), .LANES(4)) bus ();

  vec_div_sequencer #(.N(8), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating signed divider; -128/-1 wraps to 0x80 with overflow.
  always_comb begin
    q_model     = int'($signed(bus.div_a)) / int'($signed(bus.div_b));
    bus.div_out = q_model[7:0];
    bus.div_ovf = (bus.div_a == 8'h80) && (bus.div_b == 8'hFF);
  end

  task automatic run_vector(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    @(negedge clk);
    bus.a_vec = a;
    bus.b_vec = b;
    bus.mask  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cnt  = 0;
    done_at   = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        lane_da[c] = bus.div_a;
        lane_db[c] = bus.div_b;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_vec = '0;
    bus.b_vec = '0;
    bus.mask  = '0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result); end
    checks++; if ({bus.ovf_flags, bus.dz_flags} !== 8'h00) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 00000000", {bus.ovf_flags, bus.dz_flags}); end
    checks++; if ({bus.div_a, bus.div_b} !== 16'h0001) begin failures++; $display("[TB] FAIL reset_div_drive: got %h expected 0001", {bus.div_a, bus.div_b}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_vector(A_BASIC, B_BASIC, 4'b1111);
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 4", done_at); end
    checks++; if (busy_cnt !== 4) begin failures++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 4", busy_cnt); end
    checks++; if (bus.result !== R_BASIC) begin failures++; $display("[TB] FAIL basic_result: got %h expected %h", bus.result, R_BASIC); end
    checks++; if ({bus.ovf_flags, bus.dz_flags} !== 8'h00) begin failures++; $display("[TB] FAIL basic_flags: got %b expected 00000000", {bus.ovf_flags, bus.dz_flags}); end
    checks++; if ({lane_da[0], lane_db[0]} !== 16'h1403) begin failures++; $display("[TB] FAIL basic_lane0_drive: got %h expected 1403", {lane_da[0], lane_db[0]}); end
    @(posedge clk);
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("[TB] FAIL basic_idle_after_done: got %b expected 00", {bus.busy, bus.done}); end
    checks++; if (bus.result !== R_BASIC) begin failures++; $display("[TB] FAIL basic_result_hold: got %h expected %h", bus.result, R_BASIC); end
  endtask

  task automatic test_div_zero();
    run_vector(A_DZ, B_DZ, 4'b1111);
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL dz_latency: got %0d expected 4", done_at); end
    checks++; if (bus.result !== R_DZ) begin failures++; $display("[TB] FAIL dz_result: got %h expected %h", bus.result, R_DZ); end
    checks++; if (bus.dz_flags !== 4'b0010) begin failures++; $display("[TB] FAIL dz_flags: got %b expected 0010", bus.dz_flags); end
    checks++; if (bus.ovf_flags !== 4'b0000) begin failures++; $display("[TB] FAIL dz_ovf_flags: got %b expected 0000", bus.ovf_flags); end
    checks++; if ({lane_da[1], lane_db[1]} !== 16'h0001) begin failures++; $display("[TB] FAIL dz_lane1_drive: got %h expected 0001", {lane_da[1], lane_db[1]}); end
  endtask

  task automatic test_overflow();
    run_vector(32'h800A8080, 32'hFF030201, 4'b1111);
    checks++; if (bus.result !== 32'h8003C080) begin failures++; $display("[TB] FAIL ovf_result: got %h expected 8003c080", bus.result); end
    checks++; if (bus.ovf_flags !== 4'b1000) begin failures++; $display("[TB] FAIL ovf_flags: got %b expected 1000", bus.ovf_flags); end
    checks++; if (bus.dz_flags !== 4'b0000) begin failures++; $display("[TB] FAIL ovf_dz_flags: got %b expected 0000", bus.dz_flags); end
  endtask

  task automatic test_masking();
    run_vector(A_BASIC, B_BASIC, 4'b0101);
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL mask_latency: got %0d expected 4", done_at); end
    checks++; if (bus.result !== 32'h00FE0006) begin failures++; $display("[TB] FAIL mask_result: got %h expected 00fe0006", bus.result); end
    checks++; if ({bus.ovf_flags, bus.dz_flags} !== 8'h00) begin failures++; $display("[TB] FAIL mask_flags: got %b expected 00000000", {bus.ovf_flags, bus.dz_flags}); end
    checks++; if ({lane_da[1], lane_db[1]} !== 16'h0001) begin failures++; $display("[TB] FAIL mask_lane1_drive: got %h expected 0001", {lane_da[1], lane_db[1]}); end
    checks++; if ({lane_da[3], lane_db[3]} !== 16'h0001) begin failures++; $display("[TB] FAIL mask_lane3_drive: got %h expected 0001", {lane_da[3], lane_db[3]}); end
    checks++; if ({lane_da[2], lane_db[2]} !== 16'h09FC) begin failures++; $display("[TB] FAIL mask_lane2_drive: got %h expected 09fc", {lane_da[2], lane_db[2]}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.a_vec = A_BASIC;
    bus.b_vec = B_BASIC;
    bus.mask  = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a_vec = A_DZ;
    bus.b_vec = B_DZ;
    done_at = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d expected 4", done_at); end
    checks++; if (bus.result !== R_BASIC) begin failures++; $display("[TB] FAIL b2b_first_result: got %h expected %h", bus.result, R_BASIC); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_reaccept: got %b expected 10", {bus.busy, bus.done}); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL b2b_clear_result: got %h expected 00000000", bus.result); end
    done_at = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL b2b_second_latency: got %0d expected 4", done_at); end
    checks++; if (bus.result !== R_DZ) begin failures++; $display("[TB] FAIL b2b_second_result: got %h expected %h", bus.result, R_DZ); end
    checks++; if (bus.dz_flags !== 4'b0010) begin failures++; $display("[TB] FAIL b2b_second_dz: got %b expected 0010", bus.dz_flags); end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    @(negedge clk);
    bus.a_vec = A_BASIC;
    bus.b_vec = B_BASIC;
    bus.mask  = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++; if (bus.result !== 32'h0000FD06) begin failures++; $display("[TB] FAIL rst_partial_result: got %h expected 0000fd06", bus.result); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("[TB] FAIL rst_async_ctrl: got %b expected 00", {bus.busy, bus.done}); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL rst_async_result: got %h expected 00000000", bus.result); end
    checks++; if ({bus.div_a, bus.div_b} !== 16'h0001) begin failures++; $display("[TB] FAIL rst_async_div_drive: got %h expected 0001", {bus.div_a, bus.div_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("[TB] FAIL rst_no_done: got %0d active cycles expected 0", done_seen); end
    run_vector(A_BASIC, B_BASIC, 4'b1111);
    checks++; if (done_at !== 4) begin failures++; $display("[TB] FAIL rst_restart_latency: got %0d expected 4", done_at); end
    checks++; if (bus.result !== R_BASIC) begin failures++; $display("[TB] FAIL rst_restart_result: got %h expected %h", bus.result, R_BASIC); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_masking();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_div_sequencer.md
# vec_div_sequencer

Sequencer that time-multiplexes one shared combinational signed divider (`divisor`, N-bit) across the LANES elements of a vector divide instruction in the Execute stage. It latches both operand vectors and the lane mask on `start`, then issues one lane per cycle to the divider. It captures each quotient and overflow flag, and handles divide-by-zero locally. It raises `done` for one cycle when the full result vector is valid.

## Interface
- `N`, 8, element width in bits; must match the shared divider's width.
- `LANES`, 4, vector length; lane i occupies bits [i*N +: N].
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a vector divide; accepted only in IDLE or DONE.
- `a_vec`  in  LANES*N  signed dividends, sampled at acceptance.
- `b_vec`  in  LANES*N  signed divisors, sampled at acceptance.
- `mask`  in  LANES  lane enables, sampled at acceptance.
- `div_a`  out  N  dividend driven to the shared divider.
- `div_b`  out  N  divisor driven to the shared divider.
- `div_out`  in  N  quotient returned by the divider (combinational).
- `div_ovf`  in  1  overflow returned by the divider.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; the result vector and flags are valid.
- `result`  out  LANES*N  quotient vector.
- `ovf_flags`  out  LANES  per-lane overflow.
- `dz_flags`  out  LANES  per-lane divide-by-zero.

## Operation
- States: IDLE, RUN, DONE. The lane index `idx` is a counter, 0..LANES-1.
- IDLE/DONE with `start`=1 at an edge:
  - latch `a_vec`/`b_vec`/`mask`;
  - clear `result`, `ovf_flags` and `dz_flags` to 0;
  - set `idx`=0 and go to RUN.
- IDLE with `start`=0: stay in IDLE. DONE with `start`=0: go to IDLE. `result` and the flags hold their values in both cases.
- RUN, lane `idx`, written at the closing edge:
  - `mask[idx]`=0: the lane stays 0 and both flags stay 0.
  - `mask[idx]`=1 and B lane = 0:
    - result lane = all ones (0xFF for N=8);
    - `dz_flags[idx]`=1, `ovf_flags[idx]`=0;
    - the divider output is ignored.
  - Otherwise: result lane = `div_out`, `ovf_flags[idx]` = `div_ovf`.
  - If `idx`=LANES-1, go to DONE. Otherwise `idx`+1.
- Divider drive:
  - In RUN with the lane enabled and B≠0: `div_a`/`div_b` = the latched lanes.
  - In all other cases: `div_a`=0, `div_b`=1. The divider never sees a zero divisor.
- Arithmetic is signed and truncates toward zero. The quotient is the low N bits.
- -2^(N-1) / -1 gives quotient 0x80 (N=8) with ovf=1, as reported by the divider.
- `start` during RUN is ignored. The latched operands are unaffected by input changes after acceptance.

## Timing
- Reset (async, rst_n=0): state IDLE, `idx`=0, `busy`=0, `done`=0, `result`=0, `ovf_flags`=0, `dz_flags`=0, latched operands 0.
- Reset mid-RUN aborts immediately. No `done` pulse is issued and partial results are cleared.
- Acceptance is at edge k.
- `busy`=1 from edge k to edge k+LANES.
- Lane i is written at edge k+1+i.
- `done`=1 for the single cycle between edges k+LANES and k+LANES+1. `busy` is 0 in that cycle.
- Latency, start to done: LANES cycles. Throughput: one vector every LANES+1 cycles.
- Back-to-back: `start`=1 during DONE is accepted at edge k+LANES+1. The clear and relaunch are identical to acceptance from IDLE.
- `done` and `busy` are registered outputs. `div_a`/`div_b` are combinational from state, `idx` and the latched operands.
- The path through the divider must close in one cycle.

## Test plan
All scenarios use N=8, LANES=4, with vectors listed as lane0..lane3.
- Basic divide:
  - stimulus: A=(20,-7,9,127), B=(3,2,-4,1), mask=1111, start pulse;
  - response: result=(6,-3,-2,127), ovf=0000, dz=0000; `done` exactly 4 cycles after acceptance, `busy` high 4 cycles.
- Divide by zero:
  - stimulus: A=(5,5,5,5), B=(1,0,5,-1);
  - response: result=(5,0xFF,1,-5), dz=0010; `div_b`=1 during the lane-1 cycle.
- Overflow:
  - stimulus: A=(-128,-128,10,-128), B=(1,2,3,-1);
  - response: result=(-128,-64,3,0x80), ovf=1000.
- Masking:
  - stimulus: as the basic case with mask=0101;
  - response: result=(6,0,-2,0), flags 0; `div_a`=0 and `div_b`=1 in the lane-1 and lane-3 cycles; `done` still 4 cycles after acceptance.
- Handshake:
  - stimulus: `start` held high continuously, with operand inputs changed mid-RUN;
  - response: second acceptance at the DONE cycle's edge; the first results match the originally latched operands; the outputs clear at the second acceptance.
- Reset:
  - stimulus: `rst_n` low during the lane-2 cycle;
  - response: all outputs 0 asynchronously, no `done`; a fresh start afterwards completes normally.
